// File: rtl/zzzap_ctrl_pkg.sv
// Shared constants and types for the wheel/pedal control path.
package zzzap_ctrl_pkg;

  // Steering hold state machine
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHoldR = 2'd1,
    StHoldL = 2'd2
  } steer_state_e;

  // Hold counter is 5 bits and saturates
  localparam int unsigned HoldW   = 5;
  localparam logic [4:0]  HoldThr1 = 5'd8;
  localparam logic [4:0]  HoldThr2 = 5'd16;
  localparam logic [4:0]  HoldMax  = 5'd31;

  // Step table: the wheel accelerates the longer a direction is held
  localparam logic [2:0] StepSlow = 3'd1;
  localparam logic [2:0] StepMid  = 3'd2;
  localparam logic [2:0] StepFast = 3'd4;

  function automatic logic [2:0] hold_step(input logic [4:0] cnt);
    if (cnt < HoldThr1) begin
      return StepSlow;
    end else if (cnt < HoldThr2) begin
      return StepMid;
    end else begin
      return StepFast;
    end
  endfunction

endpackage

// File: rtl/btn_debounce_toggle.sv
// Debounces a button and flips a toggle state on each accepted press.
module btn_debounce_toggle #(
  parameter logic [15:0] DEBOUNCE = 16'd40000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic state
);

  logic        level_q;
  logic [15:0] cnt_q;
  logic        rise_q;
  logic        state_q;

  // Accept a new level after DEBOUNCE consecutive differing samples; toggle one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
      cnt_q   <= 16'd0;
      rise_q  <= 1'b0;
      state_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      if (btn == level_q) begin
        cnt_q <= 16'd0;
      end else if (cnt_q == DEBOUNCE - 16'd1) begin
        level_q <= btn;
        cnt_q   <= 16'd0;
        rise_q  <= btn;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (rise_q) begin
        state_q <= ~state_q;
      end
    end
  end

  assign state = state_q;

endmodule

// File: rtl/wheel_pedal_emulator.sv
// Converts digital player controls into frame-paced steering wheel and pedal positions.
module wheel_pedal_emulator
  import zzzap_ctrl_pkg::*;
#(
  parameter logic [7:0]  STEER_MIN    = 8'h30,
  parameter logic [7:0]  STEER_MAX    = 8'hB0,
  parameter logic [7:0]  STEER_CENTER = 8'h70,
  parameter logic [7:0]  CENTER_STEP  = 8'd2,
  parameter logic [7:0]  PEDAL_STEP   = 8'd8,
  parameter logic [15:0] DEBOUNCE     = 16'd40000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       steer_plus,
  input  logic       steer_minus,
  input  logic       gas_plus,
  input  logic       gas_minus,
  input  logic       gear_btn,
  output logic [7:0] steering,
  output logic [7:0] pedal,
  output logic       gear,
  output logic       frame_tick
);

  steer_state_e      state_q, state_d;
  logic [HoldW-1:0]  hold_q;
  logic [7:0]        steer_q, steer_d;
  logic [7:0]        pedal_q, pedal_d;
  logic              vsync_q;

  logic              want_r, want_l;
  logic [8:0]        step9, sum9, dif9;
  logic [8:0]        psum9, pdif9;

  // vsync_q resets high so a vsync already high at reset release gives no tick
  assign frame_tick = vsync & ~vsync_q & ~reset;

  assign want_r = steer_plus & ~steer_minus;
  assign want_l = steer_minus & ~steer_plus;

  // Next steer state and next wheel position, all math in 9 bits to avoid wrap
  always_comb begin
    state_d = StIdle;
    if (want_r) begin
      state_d = StHoldR;
    end else if (want_l) begin
      state_d = StHoldL;
    end

    step9   = {6'd0, hold_step(hold_q)};
    sum9    = {1'b0, steer_q} + step9;
    dif9    = {1'b0, steer_q} - step9;
    steer_d = steer_q;
    case (state_q)
      StHoldR: begin
        steer_d = (sum9 > {1'b0, STEER_MAX}) ? STEER_MAX : sum9[7:0];
      end
      StHoldL: begin
        steer_d = (dif9[8] || (dif9 < {1'b0, STEER_MIN})) ? STEER_MIN : dif9[7:0];
      end
      default: begin
        // Self-centre, landing exactly on centre
        if (steer_q > STEER_CENTER) begin
          steer_d = ((steer_q - STEER_CENTER) > CENTER_STEP) ? steer_q - CENTER_STEP
                                                               : STEER_CENTER;
        end else if (steer_q < STEER_CENTER) begin
          steer_d = ((STEER_CENTER - steer_q) > CENTER_STEP) ? steer_q + CENTER_STEP
                                                               : STEER_CENTER;
        end
      end
    endcase
  end

  // Next pedal position, saturating at both ends
  always_comb begin
    psum9   = {1'b0, pedal_q} + {1'b0, PEDAL_STEP};
    pdif9   = {1'b0, pedal_q} - {1'b0, PEDAL_STEP};
    pedal_d = pedal_q;
    if (gas_plus && !gas_minus) begin
      pedal_d = psum9[8] ? 8'hFF : psum9[7:0];
    end else if (gas_minus && !gas_plus) begin
      pedal_d = pdif9[8] ? 8'h00 : pdif9[7:0];
    end
  end

  // Steer FSM: state follows inputs every cycle, wheel moves only on frame ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      hold_q  <= '0;
      steer_q <= STEER_CENTER;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        hold_q <= '0;
      end else if (frame_tick && (state_q != StIdle) && (hold_q != HoldMax)) begin
        hold_q <= hold_q + 5'd1;
      end
      if (frame_tick) begin
        steer_q <= steer_d;
      end
    end
  end

  // Pedal register and vsync edge history
  always_ff @(posedge clk) begin
    if (reset) begin
      pedal_q <= 8'h00;
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync;
      if (frame_tick) begin
        pedal_q <= pedal_d;
      end
    end
  end

  btn_debounce_toggle #(
    .DEBOUNCE(DEBOUNCE)
  ) u_gear (
    .clk   (clk),
    .reset (reset),
    .btn   (gear_btn),
    .state (gear)
  );

  assign steering = steer_q;
  assign pedal    = pedal_q;

endmodule

// File: tb/tb_wheel_pedal_emulator.sv
// Directed bench for wheel_pedal_emulator: frame stepping, saturation, debounce, reset.
module tb_wheel_pedal_emulator;

  // Short debounce so press/bounce sequences stay brief
  localparam logic [15:0] Deb = 16'd400;

  logic       clk = 1'b0;
  logic       reset, vsync;
  logic       sp, sm, gp, gm, gb;
  logic [7:0] steering, pedal;
  logic       gear, frame_tick;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wheel_pedal_emulator #(
    .DEBOUNCE(Deb)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .steer_plus  (sp),
    .steer_minus (sm),
    .gas_plus    (gp),
    .gas_minus   (gm),
    .gear_btn    (gb),
    .steering    (steering),
    .pedal       (pedal),
    .gear        (gear),
    .frame_tick  (frame_tick)
  );

  typedef struct {
    logic       sp, sm, gp, gm;
    int         frames;
    logic [7:0] st, pd;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame: vsync high for two cycles, tick must be high only in the first
  task automatic frame();
    cyc(1);
    vsync = 1'b1;
    #1 check("tick_high", 32'(frame_tick), 32'd1);
    cyc(1);
    check("tick_one_cycle", 32'(frame_tick), 32'd0);
    vsync = 1'b0;
    cyc(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp;
    vecs[0]  = '{sp:0, sm:1, gp:0, gm:0, frames:60, st:8'h30, pd:8'h00};
    vecs[1]  = '{sp:1, sm:1, gp:0, gm:0, frames:10, st:8'h44, pd:8'h00};
    vecs[2]  = '{sp:0, sm:0, gp:0, gm:0, frames:30, st:8'h70, pd:8'h00};
    vecs[3]  = '{sp:0, sm:0, gp:1, gm:0, frames:31, st:8'h70, pd:8'hF8};
    vecs[4]  = '{sp:0, sm:0, gp:1, gm:0, frames:1,  st:8'h70, pd:8'hFF};
    vecs[5]  = '{sp:0, sm:0, gp:1, gm:0, frames:8,  st:8'h70, pd:8'hFF};
    vecs[6]  = '{sp:0, sm:0, gp:1, gm:1, frames:5,  st:8'h70, pd:8'hFF};
    vecs[7]  = '{sp:0, sm:0, gp:0, gm:1, frames:1,  st:8'h70, pd:8'hF7};
    vecs[8]  = '{sp:0, sm:0, gp:0, gm:1, frames:39, st:8'h70, pd:8'h00};
    vecs[9]  = '{sp:1, sm:0, gp:1, gm:0, frames:3,  st:8'h73, pd:8'h18};
    vecs[10] = '{sp:0, sm:1, gp:0, gm:0, frames:1,  st:8'h72, pd:8'h18};
    vecs[11] = '{sp:0, sm:0, gp:0, gm:0, frames:5,  st:8'h70, pd:8'h18};

    // Reset with vsync held high
    reset = 1'b1; vsync = 1'b1;
    sp = 0; sm = 0; gp = 0; gm = 0; gb = 0;
    cyc(3);
    check("rst_steering", 32'(steering), 32'h70);
    check("rst_pedal", 32'(pedal), 32'h00);
    check("rst_gear", 32'(gear), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    reset = 1'b0;
    cyc(1);
    check("post_rst_tick0", 32'(frame_tick), 32'd0);
    cyc(1);
    check("post_rst_tick1", 32'(frame_tick), 32'd0);
    vsync = 1'b0;
    cyc(1);
    check("vsync_fall_tick", 32'(frame_tick), 32'd0);
    frame();
    check("idle_frame_steer", 32'(steering), 32'h70);

    // Accelerating hold to the right
    sp = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      frame();
      exp = (k <= 8) ? 'h70 + k : (k <= 16) ? 'h78 + 2 * (k - 8) : 'h88 + 4 * (k - 16);
      check("hold_right", 32'(steering), 32'(exp));
    end

    // Self-centre back from 0x98
    sp = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      frame();
      check("centre_return", 32'(steering), 32'('h98 - 2 * k));
    end
    repeat (3) begin
      frame();
      check("centre_stay", 32'(steering), 32'h70);
    end

    // 0x71 lands on centre in one frame
    sp = 1'b1;
    frame();
    check("one_step_right", 32'(steering), 32'h71);
    sp = 1'b0;
    frame();
    check("centre_clamp", 32'(steering), 32'h70);

    // Reset mid-hold abandons the hold
    sp = 1'b1;
    repeat (3) frame();
    check("pre_reset_hold", 32'(steering), 32'h73);
    reset = 1'b1;
    cyc(1);
    sp = 1'b0;
    reset = 1'b0;
    check("reset_mid_hold", 32'(steering), 32'h70);
    frame();
    check("after_reset_idle", 32'(steering), 32'h70);

    // Table of steady-state vectors
    for (int i = 0; i < 12; i++) begin
      sp = vecs[i].sp; sm = vecs[i].sm; gp = vecs[i].gp; gm = vecs[i].gm;
      repeat (vecs[i].frames) frame();
      check($sformatf("vec%0d_steering", i), 32'(steering), 32'(vecs[i].st));
      check($sformatf("vec%0d_pedal", i), 32'(pedal), 32'(vecs[i].pd));
      check($sformatf("vec%0d_gear", i), 32'(gear), 32'd0);
    end
    sp = 0; sm = 0; gp = 0; gm = 0;

    // Bounces shorter than the debounce window
    gb = 1'b1; cyc(100);
    gb = 1'b0; cyc(50);
    gb = 1'b1; cyc(399);
    gb = 1'b0; cyc(10);
    check("bounce_no_toggle", 32'(gear), 32'd0);

    // Clean press: level accepted on sample 400, gear flips one cycle later
    gb = 1'b1;
    cyc(400);
    check("press_before_toggle", 32'(gear), 32'd0);
    cyc(1);
    check("press_toggle", 32'(gear), 32'd1);
    cyc(99);
    check("press_held_once", 32'(gear), 32'd1);
    gb = 1'b0;
    cyc(450);
    check("release_no_effect", 32'(gear), 32'd1);

    // Second press with the toggle landing on a frame tick
    gb = 1'b1; gp = 1'b1;
    cyc(400);
    check("press2_before", 32'(gear), 32'd1);
    vsync = 1'b1;
    cyc(1);
    check("simul_gear", 32'(gear), 32'd0);
    check("simul_pedal", 32'(pedal), 32'h20);
    check("simul_steering", 32'(steering), 32'h70);
    vsync = 1'b0; gp = 1'b0;
    cyc(3);
    check("simul_pedal_hold", 32'(pedal), 32'h20);
    gb = 1'b0;
    cyc(450);

    // Reset mid-debounce restarts the stable count
    gb = 1'b1;
    cyc(300);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("rst_db_gear", 32'(gear), 32'd0);
    check("rst_db_pedal", 32'(pedal), 32'h00);
    cyc(400);
    check("rst_db_no_early", 32'(gear), 32'd0);
    cyc(1);
    check("rst_db_toggle", 32'(gear), 32'd1);
    gb = 1'b0;
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wheel_pedal_emulator.md
WHEEL_PEDAL_EMULATOR -- requirements
Module: wheel_pedal_emulator

Interface
REQ-001 SHALL have parameter STEER_MIN, default 8'h30, lower steering bound.
REQ-002 SHALL have parameter STEER_MAX, default 8'hB0, upper steering bound.
REQ-003 SHALL have parameter STEER_CENTER, default 8'h70, rest position.
REQ-004 SHALL have parameter CENTER_STEP, default 2, self-centre step per frame.
REQ-005 SHALL have parameter PEDAL_STEP, default 8, pedal step per frame.
REQ-006 SHALL have parameter DEBOUNCE, default 16'd40000, gear button stable-cycle count.
REQ-007 SHALL have port clk, input, 1, core clock (clk_core domain); one clock; reset is synchronous and active-high.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port vsync, input, 1, video vertical sync (frame pacing; clk domain).
REQ-010 SHALL have ports steer_plus, steer_minus, gas_plus, gas_minus, gear_btn, input, 1 each, active-high player controls.
REQ-011 SHALL have port steering, output, 8, unsigned wheel position STEER_MIN..STEER_MAX.
REQ-012 SHALL have port pedal, output, 8, unsigned pedal position 0..255.
REQ-013 SHALL have port gear, output, 1, 0=low gear, 1=high gear.
REQ-014 SHALL have port frame_tick, output, 1, one-cycle pulse marking each update.

Function
REQ-015 SHALL register vsync each clk; frame_tick = vsync & ~vsync_q (rising edge), high exactly one cycle.
REQ-016 steering and pedal SHALL change only at the clock edge ending a frame_tick cycle; never otherwise.
REQ-017 Steer state machine states: IDLE, HOLD_R, HOLD_L; IDLE->HOLD_R on steer_plus only, IDLE->HOLD_L on steer_minus only, any HOLD->IDLE on neither or both; HOLD_R<->HOLD_L directly on reversal.
REQ-018 Frame hold counter (5 bits, saturating at 31) SHALL clear on every state transition and increment on each tick in a HOLD state.
REQ-019 Step in HOLD SHALL be 1 while hold counter <8, 2 while <16, 4 otherwise; HOLD_R adds, HOLD_L subtracts.
REQ-020 Steering SHALL saturate at STEER_MAX/STEER_MIN; computation in 9 bits, no wrap.
REQ-021 In IDLE, steering SHALL move toward STEER_CENTER by CENTER_STEP, clamped to land exactly on centre, never overshoot.
REQ-022 Pedal: gas_plus only -> +PEDAL_STEP saturating at 255; gas_minus only -> -PEDAL_STEP saturating at 0; both or neither -> hold.
REQ-023 gear_btn SHALL be debounced: accepted level changes only after DEBOUNCE consecutive equal samples.
REQ-024 gear SHALL toggle one cycle after each debounced 0->1 transition; releases have no effect.
REQ-025 Simultaneous gear toggle and frame_tick SHALL both take effect in the same cycle.

Reset
REQ-026 On reset: steering=STEER_CENTER, pedal=0, gear=0, frame_tick=0, state=IDLE, hold counter=0, debounced level=0, debounce counter=0, vsync_q=1 (no false tick on the first cycle after reset).
REQ-027 Reset asserted mid-hold or mid-debounce SHALL abandon the operation; no toggle or step issued.

Structure
REQ-028 Constants for step table, hold thresholds and state enum SHALL live in shared package zzzap_ctrl_pkg.
REQ-029 Gear debounce+toggle SHALL be a sub-module btn_debounce_toggle (clk, reset, btn, state).

Verification
REQ-030 Hold steer_plus 20 frames from reset -> steering 0x70,0x71..0x78 (frames 1-8), +2 to 0x88 (frames 9-16), +4 to 0x98 (frame 20).
REQ-031 Release at 0x98 -> steering decreases by 2 per frame, reaches 0x70 after 20 frames, stays there; from 0x71 -> 0x70 in one frame.
REQ-032 Hold steer_minus 60 frames -> steering saturates at 0x30, never below; press both -> state IDLE, centre return.
REQ-033 gas_plus 40 frames -> pedal reaches 0xFF at frame 32 and holds; gas_minus 40 frames -> 0x00, no wrap.
REQ-034 gear_btn bounce pulses <DEBOUNCE cycles -> gear unchanged; clean 50000-cycle press -> gear 0->1 exactly once; second press -> 0.
REQ-035 Reset asserted with vsync high, then released -> no frame_tick until next vsync rising edge; all outputs at reset values.
